core_dmem_stage: RTL and testbench

//  Memory stage: producer end of the writeback handshake. Accepts one op per handshake from execute.
//  For loads/stores: checks alignment, drives a single-outstanding data-bus request (store lanes and byte enables

---
 rtl/core_dmem_stage.sv | 131 +++++++++++++
 tb/tb_core_dmem_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/core_dmem_stage.sv
// Memory stage: accepts one op per handshake from execute, issues at most one
// outstanding data-bus transfer for aligned loads/stores, and holds the result
// (raw bus word, access type, addr[1:0], payload) for writeback.
module core_dmem_stage #(
   parameter int unsigned PAYLOAD_W = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_mem_read,
   input  logic                 in_mem_write,
   input  logic [2:0]           in_mem_type,
   input  logic [31:0]          in_addr,
   input  logic [31:0]          in_wdata,
   input  logic [PAYLOAD_W-1:0] in_payload,
   input  logic                 flush,
   output logic                 bus_req,
   output logic                 bus_we,
   output logic [31:0]          bus_addr,
   output logic [3:0]           bus_be,
   output logic [31:0]          bus_wdata,
   input  logic                 bus_ack,
   input  logic [31:0]          bus_rdata,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_mem_rdata,
   output logic [2:0]           out_mem_type,
   output logic [1:0]           out_addr_lo,
   output logic                 out_misalign,
   output logic [PAYLOAD_W-1:0] out_payload
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUS   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state;
   logic   kill;

   logic       accept;
   logic       is_mem;
   logic       misalign;
   logic [3:0] be_next;
   logic [31:0] wdata_next;

   // Handshake to execute; flush blocks any new op this cycle.
   always_comb begin
      in_ready = !flush && ((state == EMPTY) || ((state == FULL) && out_ready));
      accept   = in_valid && in_ready;
   end

   // Alignment check and store lane / byte-enable steering for the incoming op.
   always_comb begin
      is_mem     = in_mem_read || in_mem_write;
      misalign   = 1'b0;
      be_next    = 4'hF;
      wdata_next = in_wdata;
      case (in_mem_type[1:0])
         2'd0: begin
            if (in_mem_write) be_next = 4'b0001 << in_addr[1:0];
            wdata_next = {4{in_wdata[7:0]}};
         end
         2'd1: begin
            misalign = in_addr[0];
            if (in_mem_write) be_next = 4'b0011 << in_addr[1:0];
            wdata_next = {2{in_wdata[15:0]}};
         end
         default: begin
            misalign = (in_addr[1:0] != 2'b00);
         end
      endcase
      misalign = misalign && is_mem;
   end

   assign bus_req   = (state == BUS);
   assign out_valid = (state == FULL);

   // Stage state machine, bus request fields and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= EMPTY;
         kill          <= 1'b0;
         bus_we        <= 1'b0;
         bus_addr      <= '0;
         bus_be        <= '0;
         bus_wdata     <= '0;
         out_mem_rdata <= '0;
         out_mem_type  <= '0;
         out_addr_lo   <= '0;
         out_misalign  <= 1'b0;
         out_payload   <= '0;
      end else begin
         case (state)
            BUS: begin
               if (flush) kill <= 1'b1;
               if (bus_ack) begin
                  kill <= 1'b0;
                  if (!bus_we) out_mem_rdata <= bus_rdata;
                  state <= (kill || flush) ? EMPTY : FULL;
               end
            end
            FULL: begin
               if (flush || out_ready) state <= EMPTY;
            end
            default: ;
         endcase
         // accept is only possible from EMPTY or a draining FULL, so it
         // overrides the drain-to-EMPTY above for a same-cycle reload.
         if (accept) begin
            out_mem_type  <= in_mem_type;
            out_addr_lo   <= in_addr[1:0];
            out_payload   <= in_payload;
            out_misalign  <= misalign;
            out_mem_rdata <= '0;
            if (is_mem && !misalign) begin
               state     <= BUS;
               bus_we    <= in_mem_write;
               bus_addr  <= {in_addr[31:2], 2'b00};
               bus_be    <= be_next;
               bus_wdata <= wdata_next;
            end else begin
               state <= FULL;
            end
         end
      end
   end

endmodule

// File: tb/tb_core_dmem_stage.sv
// Directed bench for core_dmem_stage: inputs change and outputs are sampled
// on the falling edge, away from the active rising edge.
module tb_core_dmem_stage;

   localparam int unsigned PW = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic          in_mem_read;
   logic          in_mem_write;
   logic [2:0]    in_mem_type;
   logic [31:0]   in_addr;
   logic [31:0]   in_wdata;
   logic [PW-1:0] in_payload;
   logic          flush;
   logic          bus_req;
   logic          bus_we;
   logic [31:0]   bus_addr;
   logic [3:0]    bus_be;
   logic [31:0]   bus_wdata;
   logic          bus_ack;
   logic [31:0]   bus_rdata;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_mem_rdata;
   logic [2:0]    out_mem_type;
   logic [1:0]    out_addr_lo;
   logic          out_misalign;
   logic [PW-1:0] out_payload;

   int checks = 0;
   int errors = 0;

   core_dmem_stage #(.PAYLOAD_W(PW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
      .in_mem_type(in_mem_type), .in_addr(in_addr), .in_wdata(in_wdata),
      .in_payload(in_payload), .flush(flush),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_mem_rdata(out_mem_rdata), .out_mem_type(out_mem_type),
      .out_addr_lo(out_addr_lo), .out_misalign(out_misalign),
      .out_payload(out_payload)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic drive_op(input logic rd, input logic wr, input logic [2:0] typ,
                           input logic [31:0] addr, input logic [31:0] d, input logic [63:0] pl);
      in_valid = 1'b1; in_mem_read = rd; in_mem_write = wr; in_mem_type = typ;
      in_addr = addr; in_wdata = d; in_payload = pl;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
      in_mem_type = 3'd0; in_addr = '0; in_wdata = '0; in_payload = '0;
      flush = 1'b0; bus_ack = 1'b0; bus_rdata = '0; out_ready = 1'b0;

      // Reset state
      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_bus_req", bus_req, 0);
      chk("rst_bus_be", bus_be, 0);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_rdata", out_mem_rdata, 0);
      @(negedge clk); rst = 1'b0;

      // SB 0x1003, ack after two waiting cycles
      @(negedge clk);
      drive_op(1'b0, 1'b1, 3'd0, 32'h0000_1003, 32'h0000_00AB, 64'h11);
      #1 chk("sb_in_ready", in_ready, 1);
      @(negedge clk); in_valid = 1'b0;
      chk("sb_req", bus_req, 1);
      chk("sb_we", bus_we, 1);
      chk("sb_addr", bus_addr, 32'h0000_1000);
      chk("sb_be", bus_be, 4'b1000);
      chk("sb_wdata", bus_wdata, 32'hABAB_ABAB);
      chk("sb_in_ready_busy", in_ready, 0);
      @(negedge clk);
      chk("sb_req_hold", bus_req, 1);
      chk("sb_addr_hold", bus_addr, 32'h0000_1000);
      chk("sb_ov_busy", out_valid, 0);
      @(negedge clk); bus_ack = 1'b1;
      chk("sb_req_hold2", bus_req, 1);
      @(negedge clk); bus_ack = 1'b0;
      chk("sb_req_drop", bus_req, 0);
      chk("sb_ov", out_valid, 1);
      chk("sb_payload", out_payload, 64'h11);
      chk("sb_rdata0", out_mem_rdata, 0);
      chk("sb_misalign", out_misalign, 0);
      @(negedge clk);
      chk("sb_ov_hold", out_valid, 1);
      out_ready = 1'b1;
      @(negedge clk); out_ready = 1'b0;
      chk("sb_drained", out_valid, 0);

      // SH 0x1002, ack on first request cycle
      drive_op(1'b0, 1'b1, 3'd1, 32'h0000_1002, 32'h1234_CDEF, 64'h12);
      @(negedge clk); in_valid = 1'b0;
      chk("sh_be", bus_be, 4'b1100);
      chk("sh_wdata", bus_wdata, 32'hCDEF_CDEF);
      bus_ack = 1'b1;
      @(negedge clk); bus_ack = 1'b0;
      chk("sh_ov", out_valid, 1);
      out_ready = 1'b1;
      @(negedge clk); out_ready = 1'b0;

      // LHU 0x2002, ack on first request cycle
      drive_op(1'b1, 1'b0, 3'd5, 32'h0000_2002, 32'h0, 64'h22);
      @(negedge clk); in_valid = 1'b0;
      chk("lhu_req", bus_req, 1);
      chk("lhu_we", bus_we, 0);
      chk("lhu_be", bus_be, 4'hF);
      chk("lhu_addr", bus_addr, 32'h0000_2000);
      bus_ack = 1'b1; bus_rdata = 32'hBEEF_1234;
      @(negedge clk); bus_ack = 1'b0; bus_rdata = 32'h0;
      chk("lhu_ov", out_valid, 1);
      chk("lhu_rdata", out_mem_rdata, 32'hBEEF_1234);
      chk("lhu_lo", out_addr_lo, 2);
      chk("lhu_type", out_mem_type, 5);
      out_ready = 1'b1;
      @(negedge clk); out_ready = 1'b0;

      // LW 0x2001 misaligned: no bus cycle
      drive_op(1'b1, 1'b0, 3'd2, 32'h0000_2001, 32'h0, 64'h33);
      @(negedge clk); in_valid = 1'b0;
      chk("lw_mis_req", bus_req, 0);
      chk("lw_mis_ov", out_valid, 1);
      chk("lw_mis_flag", out_misalign, 1);
      chk("lw_mis_payload", out_payload, 64'h33);
      out_ready = 1'b1;
      @(negedge clk); out_ready = 1'b0;

      // Three non-mem ops, writeback stalled for two cycles
      drive_op(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 64'hA);
      #1 chk("nm_rdy0", in_ready, 1);
      @(negedge clk); in_payload = 64'hB;
      chk("nm_ov1", out_valid, 1);
      chk("nm_pA1", out_payload, 64'hA);
      chk("nm_stall1", in_ready, 0);
      @(negedge clk);
      chk("nm_pA2", out_payload, 64'hA);
      chk("nm_stall2", in_ready, 0);
      @(negedge clk); out_ready = 1'b1;
      #1 chk("nm_rdy3", in_ready, 1);
      @(negedge clk); in_payload = 64'hC;
      chk("nm_pB", out_payload, 64'hB);
      chk("nm_ovB", out_valid, 1);
      @(negedge clk); in_valid = 1'b0;
      chk("nm_pC", out_payload, 64'hC);
      chk("nm_ovC", out_valid, 1);
      @(negedge clk); out_ready = 1'b0;
      chk("nm_done", out_valid, 0);

      // Flush in FULL empties the stage
      drive_op(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 64'h44);
      @(negedge clk); in_valid = 1'b0; flush = 1'b1;
      chk("ff_ov", out_valid, 1);
      @(negedge clk); flush = 1'b0;
      chk("ff_gone", out_valid, 0);

      // LW 0x3000 flushed in first BUS cycle, ack on third
      out_ready = 1'b1;
      drive_op(1'b1, 1'b0, 3'd2, 32'h0000_3000, 32'h0, 64'h55);
      @(negedge clk);
      chk("fl_req1", bus_req, 1);
      flush = 1'b1;
      #1 chk("fl_rdy_flush", in_ready, 0);
      @(negedge clk); flush = 1'b0; in_valid = 1'b0;
      chk("fl_req2", bus_req, 1);
      chk("fl_ov2", out_valid, 0);
      @(negedge clk);
      chk("fl_req3", bus_req, 1);
      bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
      @(negedge clk); bus_ack = 1'b0; bus_rdata = 32'h0;
      chk("fl_req_off", bus_req, 0);
      chk("fl_ov_off", out_valid, 0);
      chk("fl_rdy", in_ready, 1);
      @(negedge clk);
      chk("fl_ov_later", out_valid, 0);
      out_ready = 1'b0;

      // Asynchronous reset mid BUS
      drive_op(1'b0, 1'b1, 3'd2, 32'h0000_4000, 32'h1357_9BDF, 64'h66);
      @(negedge clk); in_valid = 1'b0;
      chk("ar_req", bus_req, 1);
      chk("ar_wdata", bus_wdata, 32'h1357_9BDF);
      #2 rst = 1'b1;
      #1;
      chk("ar_req_off", bus_req, 0);
      chk("ar_ov_off", out_valid, 0);
      chk("ar_rdy", in_ready, 1);
      chk("ar_be", bus_be, 0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      chk("ar_idle", bus_req, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
